// File: rtl/sort_arbiter.sv
// Round-robin arbiter sharing one sort engine among NREQ requesters.
// Latches the winner's array, runs the engine under a timeout, and holds the result until Ack.
module sort_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned DW      = 7,
    parameter int unsigned MAXN    = 30,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NREQ-1:0]         Req,
    input  logic [NREQ-1:0]         Ack,
    input  logic [NREQ*MAXN*DW-1:0] Ain_all,
    input  logic [NREQ*5-1:0]       width_all,
    input  logic                    eng_Done,
    input  logic [MAXN*DW-1:0]      eng_Aout,
    output logic                    eng_Start,
    output logic                    eng_Ack,
    output logic [MAXN*DW-1:0]      eng_Ain,
    output logic [4:0]              eng_width,
    output logic [NREQ-1:0]         Grant,
    output logic [NREQ-1:0]         Done,
    output logic [MAXN*DW-1:0]      Aout,
    output logic                    Err,
    output logic                    Busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;
    localparam int unsigned AW = MAXN * DW;
    localparam logic [PW-1:0] PtrInit  = PW'(NREQ - 1);
    // Counter value in the last WAIT cycle, so eng_Ack lands TIMEOUT cycles after eng_Start.
    localparam logic [CW-1:0] CntLast  = CW'(TIMEOUT - 2);
    localparam logic [5:0]    MaxWidth = 6'(MAXN);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
        StEngAck,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   ain_q, ain_d;
    logic [4:0]      width_q, width_d;
    logic [AW-1:0]   aout_q, aout_d;
    logic            err_q, err_d;

    logic            found;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   owner_idx;
    logic            width_bad;
    int unsigned     idx;

    assign width_bad = (width_q == 5'd0) || ({1'b0, width_q} > MaxWidth);

    // First requesting index after ptr, wrapping around.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            idx = (32'(ptr_q) + 32'(i)) % NREQ;
            for (int k = 0; k < int'(NREQ); k++) begin
                if (!found && Req[k] && (idx == 32'(k))) begin
                    found    = 1'b1;
                    pick_idx = PW'(k);
                end
            end
        end
    end

    always_comb begin
        owner_idx = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (grant_q[k]) begin
                owner_idx = PW'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ain_d   = ain_q;
        width_d = width_q;
        aout_d  = aout_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = NREQ'(1) << pick_idx;
                    for (int k = 0; k < int'(NREQ); k++) begin
                        if (PW'(k) == pick_idx) begin
                            ain_d   = Ain_all[k*AW +: AW];
                            width_d = width_all[k*5 +: 5];
                        end
                    end
                    state_d = StStart;
                end
            end
            StStart: begin
                // An illegal width never reaches the engine; the raw array is returned.
                if (width_bad) begin
                    err_d   = 1'b1;
                    aout_d  = ain_q;
                    state_d = StDone;
                end else begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (eng_Done) begin
                    aout_d  = eng_Aout;
                    err_d   = 1'b0;
                    state_d = StEngAck;
                end else if (cnt_q == CntLast) begin
                    aout_d  = ain_q;
                    err_d   = 1'b1;
                    state_d = StEngAck;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StEngAck: begin
                state_d = StDone;
            end
            StDone: begin
                if (|(Ack & grant_q)) begin
                    grant_d = '0;
                    ptr_d   = owner_idx;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= PtrInit;
            cnt_q   <= '0;
            ain_q   <= '0;
            width_q <= '0;
            aout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ain_q   <= ain_d;
            width_q <= width_d;
            aout_q  <= aout_d;
            err_q   <= err_d;
        end
    end

    assign eng_Start = (state_q == StStart) && !width_bad;
    assign eng_Ack   = (state_q == StEngAck);
    assign eng_Ain   = ain_q;
    assign eng_width = width_q;
    assign Grant     = grant_q;
    assign Done      = (state_q == StDone) ? grant_q : '0;
    assign Aout      = aout_q;
    assign Err       = err_q;
    assign Busy      = (state_q != StIdle);

endmodule

// File: tb/tb_sort_arbiter.sv
// Bench for sort_arbiter: behavioural sort engine, round-robin reference model and
// a second instance with a short timeout for the timeout / same-cycle race scenarios.
module tb_sort_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 7;
    localparam int MAXN = 30;
    localparam int AW   = MAXN * DW;

    logic                 Clk = 1'b0;
    logic                 Reset = 1'b1;
    logic [NREQ-1:0]      Req = '0;
    logic [NREQ-1:0]      Ack = '0;
    logic [NREQ*AW-1:0]   Ain_all = '0;
    logic [NREQ*5-1:0]    width_all = '0;
    logic                 eng_Done;
    logic [AW-1:0]        eng_Aout;
    logic                 eng_Start, eng_Ack, Err, Busy;
    logic [AW-1:0]        eng_Ain, Aout;
    logic [4:0]           eng_width;
    logic [NREQ-1:0]      Grant, Done;

    logic [NREQ-1:0]      Req_t = '0;
    logic [NREQ-1:0]      Ack_t = '0;
    logic                 eng_Done_t = 1'b0;
    logic [AW-1:0]        eng_Aout_t = '0;
    logic                 eng_Start_t, eng_Ack_t, Err_t, Busy_t;
    logic [AW-1:0]        eng_Ain_t, Aout_t;
    logic [4:0]           eng_width_t;
    logic [NREQ-1:0]      Grant_t, Done_t;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_ptr   = NREQ - 1;
    int n_start  = 0;
    int n_ack    = 0;

    logic [AW-1:0] arr [NREQ];

    sort_arbiter u_dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req       (Req),
        .Ack       (Ack),
        .Ain_all   (Ain_all),
        .width_all (width_all),
        .eng_Done  (eng_Done),
        .eng_Aout  (eng_Aout),
        .eng_Start (eng_Start),
        .eng_Ack   (eng_Ack),
        .eng_Ain   (eng_Ain),
        .eng_width (eng_width),
        .Grant     (Grant),
        .Done      (Done),
        .Aout      (Aout),
        .Err       (Err),
        .Busy      (Busy)
    );

    sort_arbiter #(.TIMEOUT(16)) u_dut_t (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req       (Req_t),
        .Ack       (Ack_t),
        .Ain_all   (Ain_all),
        .width_all (width_all),
        .eng_Done  (eng_Done_t),
        .eng_Aout  (eng_Aout_t),
        .eng_Start (eng_Start_t),
        .eng_Ack   (eng_Ack_t),
        .eng_Ain   (eng_Ain_t),
        .eng_width (eng_width_t),
        .Grant     (Grant_t),
        .Done      (Done_t),
        .Aout      (Aout_t),
        .Err       (Err_t),
        .Busy      (Busy_t)
    );

    always #5 Clk = ~Clk;

    function automatic logic [AW-1:0] sort_arr(input logic [AW-1:0] a, input int w_in);
        logic [DW-1:0] e [MAXN];
        logic [DW-1:0] t;
        logic [AW-1:0] r;
        int w;
        w = (w_in > MAXN) ? MAXN : w_in;
        for (int i = 0; i < MAXN; i++) e[i] = a[i*DW +: DW];
        for (int i = 0; i < w; i++)
            for (int j = 0; j + 1 < w - i; j++)
                if (e[j] > e[j+1]) begin
                    t = e[j]; e[j] = e[j+1]; e[j+1] = t;
                end
        for (int i = 0; i < MAXN; i++) r[i*DW +: DW] = e[i];
        return r;
    endfunction

    function automatic logic [AW-1:0] rand_arr();
        logic [AW-1:0] r;
        for (int i = 0; i < MAXN; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] rq);
        int id;
        for (int i = 1; i <= NREQ; i++) begin
            id = (ptr + i) % NREQ;
            if (rq[id]) return id;
        end
        return -1;
    endfunction

    // Behavioural engine: snapshots the array on eng_Start, answers after eng_delay cycles,
    // holds eng_Done until eng_Ack.
    int            eng_delay = 5;
    int            eng_cnt;
    logic          eng_busy;
    logic [AW-1:0] eng_snap;
    logic [4:0]    eng_wsnap;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            eng_busy <= 1'b0;
            eng_Done <= 1'b0;
            eng_cnt  <= 0;
            eng_Aout <= '0;
        end else begin
            if (eng_Start) begin
                eng_busy  <= 1'b1;
                eng_cnt   <= eng_delay;
                eng_snap  <= eng_Ain;
                eng_wsnap <= eng_width;
            end else if (eng_busy && !eng_Done) begin
                if (eng_cnt <= 1) begin
                    eng_Done <= 1'b1;
                    eng_Aout <= sort_arr(eng_snap, int'(eng_wsnap));
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
            if (eng_Ack) begin
                eng_Done <= 1'b0;
                eng_busy <= 1'b0;
            end
        end
    end

    always @(posedge Clk) begin
        if (eng_Start) n_start <= n_start + 1;
        if (eng_Ack) n_ack <= n_ack + 1;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_done(input int bound);
        int c = 0;
        while (Done === '0 && c < bound) begin
            tick();
            c++;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Req = '0; Ack = '0; Req_t = '0; Ack_t = '0; eng_Done_t = 1'b0;
        repeat (2) tick();
        Reset = 1'b0;
        tb_ptr = NREQ - 1;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        n_checks++;
        if ({Grant, Done, Busy, eng_Start, eng_Ack, Err} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0", {Grant, Done, Busy, eng_Start, eng_Ack, Err});
        end
        n_checks++;
        if ({Aout, eng_Ain, eng_width} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {Aout, eng_Ain, eng_width});
        end
        do_reset();
        n_checks++;
        if ({Busy, Busy_t, Grant_t} !== '0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b want 0", {Busy, Busy_t, Grant_t});
        end
    endtask

    task automatic test_single();
        logic [AW-1:0] a;
        int s0, a0;
        for (int i = 0; i < MAXN; i++) a[i*DW +: DW] = DW'((i * 17) % 113);
        Ain_all[0 +: AW] = a;
        width_all[0 +: 5] = 5'd30;
        eng_delay = 2000;
        s0 = n_start; a0 = n_ack;
        Req = 3'b001;
        wait_done(2100);
        n_checks++;
        if (Done !== 3'b001) begin n_fail++; $display("FAIL single_done: got %b want 001", Done); end
        n_checks++;
        if (Err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", Err); end
        n_checks++;
        if (Aout !== sort_arr(a, 30)) begin
            n_fail++; $display("FAIL single_aout: got %h want %h", Aout, sort_arr(a, 30));
        end
        n_checks++;
        if ((n_start - s0) != 1 || (n_ack - a0) != 1) begin
            n_fail++; $display("FAIL single_pulses: got start %0d ack %0d want 1 1", n_start - s0, n_ack - a0);
        end
        Ack = 3'b001; Req = '0;
        tick();
        Ack = '0;
        n_checks++;
        if ({Done, Busy, Grant} !== '0) begin
            n_fail++; $display("FAIL single_release: got %b want 0", {Done, Busy, Grant});
        end
        tb_ptr = 0;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_oh [4];
        int              exp_id [4];
        exp_oh = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_id = '{0, 1, 2, 0};
        do_reset();
        eng_delay = 3;
        for (int k = 0; k < NREQ; k++) begin
            arr[k] = rand_arr();
            Ain_all[k*AW +: AW] = arr[k];
            width_all[k*5 +: 5] = 5'd30;
        end
        Req = 3'b111;
        for (int j = 0; j < 4; j++) begin
            wait_done(100);
            n_checks++;
            if (Done !== exp_oh[j]) begin
                n_fail++; $display("FAIL rr_order job %0d: got %b want %b", j, Done, exp_oh[j]);
            end
            n_checks++;
            if (Aout !== sort_arr(arr[exp_id[j]], 30)) begin
                n_fail++; $display("FAIL rr_aout job %0d: got %h want %h", j, Aout, sort_arr(arr[exp_id[j]], 30));
            end
            if (j == 0) begin
                Ack = 3'b010;
                tick(); tick();
                Ack = '0;
                n_checks++;
                if (Done !== 3'b001) begin
                    n_fail++; $display("FAIL rr_foreign_ack: got %b want 001", Done);
                end
            end
            Ack = exp_oh[j];
            if (j == 3) Req = '0;
            tick();
            Ack = '0;
            n_checks++;
            if (Done !== '0) begin n_fail++; $display("FAIL rr_done_clear job %0d: got %b want 000", j, Done); end
            tb_ptr = exp_id[j];
        end
    endtask

    task automatic test_bad_width();
        int s0;
        for (int t = 0; t < 2; t++) begin
            arr[1] = rand_arr();
            Ain_all[AW +: AW] = arr[1];
            width_all[5 +: 5] = (t == 0) ? 5'd0 : 5'd31;
            s0 = n_start;
            Req = 3'b010;
            tick();
            n_checks++;
            if (Done !== 3'b000 || Grant !== 3'b010 || eng_Start !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_w_first_cycle w%0d: got done %b grant %b start %b want 000 010 0",
                         t, Done, Grant, eng_Start);
            end
            tick();
            n_checks++;
            if (Done !== 3'b010 || Err !== 1'b1) begin
                n_fail++; $display("FAIL bad_w_done w%0d: got %b err %b want 010 1", t, Done, Err);
            end
            n_checks++;
            if (Aout !== arr[1] || n_start != s0) begin
                n_fail++; $display("FAIL bad_w_aout w%0d: got %h starts %0d want %h 0", t, Aout, n_start - s0, arr[1]);
            end
            Ack = 3'b010; Req = '0;
            tick();
            Ack = '0;
            tb_ptr = 1;
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] rq, oh;
        int              wv [NREQ];
        int              own;
        logic            bad;
        logic [AW-1:0]   expv;
        for (int j = 0; j < 12; j++) begin
            rq = NREQ'($urandom_range(1, 7));
            for (int k = 0; k < NREQ; k++) begin
                arr[k] = rand_arr();
                if ($urandom_range(0, 5) == 0) wv[k] = ($urandom_range(0, 1) == 1) ? 31 : 0;
                else wv[k] = $urandom_range(1, 30);
                Ain_all[k*AW +: AW] = arr[k];
                width_all[k*5 +: 5] = 5'(wv[k]);
            end
            eng_delay = $urandom_range(1, 20);
            own = rr_pick(tb_ptr, rq);
            oh = NREQ'(1 << own);
            bad = (wv[own] == 0) || (wv[own] > MAXN);
            expv = bad ? arr[own] : sort_arr(arr[own], wv[own]);
            Req = rq;
            tick();
            n_checks++;
            if (Grant !== oh || eng_Ain !== arr[own] || eng_width !== 5'(wv[own])) begin
                n_fail++; $display("FAIL rand_grant job %0d: got %b w%0d want %b w%0d", j, Grant, eng_width, oh, wv[own]);
            end
            // Inputs move while the job is in flight; the job must not notice.
            Req = NREQ'($urandom);
            for (int k = 0; k < NREQ; k++) Ain_all[k*AW +: AW] = rand_arr();
            width_all = 15'($urandom);
            wait_done(100);
            n_checks++;
            if (Done !== oh || Err !== bad) begin
                n_fail++; $display("FAIL rand_done job %0d: got %b err %b want %b err %b", j, Done, Err, oh, bad);
            end
            n_checks++;
            if (Aout !== expv || eng_Ain !== arr[own]) begin
                n_fail++; $display("FAIL rand_aout job %0d: got %h want %h", j, Aout, expv);
            end
            Ack = ~oh;
            tick();
            n_checks++;
            if (Done !== oh) begin n_fail++; $display("FAIL rand_foreign_ack job %0d: got %b want %b", j, Done, oh); end
            Ack = oh | NREQ'($urandom);
            tick();
            Ack = '0; Req = '0;
            tb_ptr = own;
        end
    endtask

    task automatic test_timeout();
        int c = 0;
        arr[0] = rand_arr();
        Ain_all[0 +: AW] = arr[0];
        width_all[0 +: 5] = 5'd20;
        eng_Done_t = 1'b0;
        Req_t = 3'b001;
        tick();
        n_checks++;
        if (eng_Start_t !== 1'b1) begin n_fail++; $display("FAIL to_start: got %b want 1", eng_Start_t); end
        while (eng_Ack_t !== 1'b1 && c < 40) begin
            tick();
            c++;
        end
        n_checks++;
        if (c != 16) begin n_fail++; $display("FAIL to_ack_latency: got %0d want 16", c); end
        tick();
        n_checks++;
        if (Done_t !== 3'b001 || Err_t !== 1'b1 || Aout_t !== arr[0]) begin
            n_fail++; $display("FAIL to_result: got %b err %b aout %h want 001 1 %h", Done_t, Err_t, Aout_t, arr[0]);
        end
        Ack_t = 3'b001; Req_t = '0;
        tick();
        Ack_t = '0;
        n_checks++;
        if (Busy_t !== 1'b0) begin n_fail++; $display("FAIL to_release: got %b want 0", Busy_t); end
    endtask

    task automatic test_done_race();
        logic [AW-1:0] pat;
        pat = rand_arr();
        arr[0] = rand_arr();
        Ain_all[0 +: AW] = arr[0];
        width_all[0 +: 5] = 5'd9;
        Req_t = 3'b001;
        tick();
        repeat (15) tick();
        n_checks++;
        if (eng_Ack_t !== 1'b0 || Busy_t !== 1'b1) begin
            n_fail++; $display("FAIL race_pre: got ack %b busy %b want 0 1", eng_Ack_t, Busy_t);
        end
        eng_Done_t = 1'b1;
        eng_Aout_t = pat;
        tick();
        eng_Done_t = 1'b0;
        n_checks++;
        if (eng_Ack_t !== 1'b1) begin n_fail++; $display("FAIL race_ack: got %b want 1", eng_Ack_t); end
        tick();
        n_checks++;
        if (Done_t !== 3'b001 || Err_t !== 1'b0 || Aout_t !== pat) begin
            n_fail++; $display("FAIL race_result: got %b err %b aout %h want 001 0 %h", Done_t, Err_t, Aout_t, pat);
        end
        Ack_t = 3'b001; Req_t = '0;
        tick();
        Ack_t = '0;
    endtask

    task automatic test_reset_mid();
        int s0, a0;
        eng_delay = 50;
        arr[0] = rand_arr();
        Ain_all[0 +: AW] = arr[0];
        width_all[0 +: 5] = 5'd10;
        Req = 3'b001;
        repeat (3) tick();
        a0 = n_ack;
        #2;
        Reset = 1'b1;
        Req = '0;
        #1;
        n_checks++;
        if ({Grant, Done, Busy, eng_Start, eng_Ack, Err} !== '0) begin
            n_fail++; $display("FAIL midreset_ctrl: got %b want 0", {Grant, Done, Busy, eng_Start, eng_Ack, Err});
        end
        n_checks++;
        if ({Aout, eng_Ain, eng_width} !== '0) begin
            n_fail++; $display("FAIL midreset_data: got %h want 0", {Aout, eng_Ain, eng_width});
        end
        tick();
        Reset = 1'b0;
        tb_ptr = NREQ - 1;
        arr[2] = rand_arr();
        Ain_all[2*AW +: AW] = arr[2];
        width_all[10 +: 5] = 5'd12;
        eng_delay = 4;
        s0 = n_start;
        Req = 3'b100;
        tick();
        n_checks++;
        if (Grant !== 3'b100 || eng_Start !== 1'b1) begin
            n_fail++; $display("FAIL midreset_regrant: got %b start %b want 100 1", Grant, eng_Start);
        end
        wait_done(100);
        n_checks++;
        if (Done !== 3'b100 || Aout !== sort_arr(arr[2], 12) || (n_start - s0) != 1 || (n_ack - a0) != 1) begin
            n_fail++; $display("FAIL midreset_job: got %b starts %0d acks %0d aout %h want 100 1 1 %h",
                               Done, n_start - s0, n_ack - a0, Aout, sort_arr(arr[2], 12));
        end
        Ack = 3'b100; Req = '0;
        tick();
        Ack = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_bad_width();
        test_random();
        test_timeout();
        test_done_race();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
